// File: rtl/tlb_assoc_if.sv
// Lookup, walk and maintenance signals of the associative TLB.
interface tlb_assoc_if #(
  parameter int VPN_W = 6,
  parameter int PFN_W = 16,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic [VPN_W-1:0] req_vpn;
  logic             req_ready;
  logic             resp_valid;
  logic [PFN_W-1:0] resp_pfn;
  logic             resp_hit;
  logic             resp_fault;
  logic             walk_req;
  logic [VPN_W-1:0] walk_vpn;
  logic             walk_ack;
  logic [PFN_W-1:0] walk_pfn;
  logic             walk_fault;
  logic             flush;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output req_valid, req_vpn, walk_ack, walk_pfn, walk_fault, flush,
    input  req_ready, resp_valid, resp_pfn, resp_hit, resp_fault,
           walk_req, walk_vpn, hit_count, miss_count
  );

  modport slave (
    input  req_valid, req_vpn, walk_ack, walk_pfn, walk_fault, flush,
    output req_ready, resp_valid, resp_pfn, resp_hit, resp_fault,
           walk_req, walk_vpn, hit_count, miss_count
  );
endinterface

// File: rtl/tlb_assoc.sv
// Fully-associative TLB: valid bits, walk-based miss refill, flush,
// first-invalid / round-robin replacement and saturating hit/miss counters.
module tlb_assoc #(
  parameter int VPN_W   = 6,
  parameter int PFN_W   = 16,
  parameter int ENTRIES = 8,
  parameter int CNT_W   = 16
) (
  input logic       Clock,
  input logic       Resetn,
  tlb_assoc_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RESP} state_t;

  state_t             state, state_nx;
  logic [VPN_W-1:0]   vpn_q;
  logic [ENTRIES-1:0] valid;
  logic [VPN_W-1:0]   tag  [ENTRIES];
  logic [PFN_W-1:0]   data [ENTRIES];
  logic [IDX_W-1:0]   rr_ptr, rr_next;
  logic               flush_pend;
  logic [CNT_W-1:0]   hit_cnt, miss_cnt;
  logic [PFN_W-1:0]   resp_pfn_q;
  logic               resp_hit_q, resp_fault_q;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               any_free;
  logic [IDX_W-1:0]   free_idx, victim;
  logic               ready, accept, refill, flush_now;

  // Tag match against all valid entries, lowest index wins
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit && valid[i] && tag[i] == vpn_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim choice: lowest invalid entry, otherwise the round-robin pointer
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!any_free && !valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    victim  = any_free ? free_idx : rr_ptr;
    rr_next = (rr_ptr == IDX_W'(ENTRIES - 1)) ? '0 : rr_ptr + 1'b1;
  end

  // FSM state register
  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nx        = state;
    ready           = 1'b0;
    bus.walk_req    = 1'b0;
    bus.resp_valid  = 1'b0;
    case (state)
      IDLE: begin
        ready = ~bus.flush & ~flush_pend;
        if (bus.req_valid && ready) state_nx = LOOKUP;
      end
      LOOKUP: state_nx = hit ? RESP : WALK;
      WALK: begin
        bus.walk_req = 1'b1;
        if (bus.walk_ack) state_nx = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept    = ready & bus.req_valid;
  assign refill    = (state == WALK) & bus.walk_ack & ~bus.walk_fault;
  assign flush_now = (state == IDLE) & (bus.flush | flush_pend);

  // Control state: valid bits, replacement pointer, flush, counters, response
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      vpn_q        <= '0;
      valid        <= '0;
      rr_ptr       <= '0;
      flush_pend   <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      resp_pfn_q   <= '0;
      resp_hit_q   <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      if (accept) vpn_q <= bus.req_vpn;
      if (state == LOOKUP) begin
        if (hit) begin
          resp_pfn_q   <= data[hit_idx];
          resp_hit_q   <= 1'b1;
          resp_fault_q <= 1'b0;
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
        end else if (miss_cnt != '1) begin
          miss_cnt <= miss_cnt + 1'b1;
        end
      end
      if (state == WALK && bus.walk_ack) begin
        resp_hit_q   <= 1'b0;
        resp_fault_q <= bus.walk_fault;
        resp_pfn_q   <= bus.walk_fault ? '0 : bus.walk_pfn;
      end
      if (refill) begin
        valid[victim] <= 1'b1;
        if (!any_free) rr_ptr <= rr_next;
      end
      // A flush seen mid-transaction is deferred to the next IDLE cycle, so it
      // also wipes the entry refilled by that transaction.
      if (flush_now) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end else if (state != IDLE && bus.flush) begin
        flush_pend <= 1'b1;
      end
    end
  end

  // Entry payload; stale contents are harmless because valid gates every use
  always_ff @(posedge Clock) begin
    if (refill) begin
      tag[victim]  <= vpn_q;
      data[victim] <= bus.walk_pfn;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.walk_vpn   = vpn_q;
  assign bus.resp_pfn   = resp_pfn_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_fault = resp_fault_q;
  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
endmodule
